led_pattern_gen: RTL and testbench

// - Parametrised multi-LED colour pattern engine; drives N_LEDS RGB PWM duty words (one PWM per colour, external).
// - Modes: rainbow cycle (R->G->B crossfade), breathe (white ramp up/down), static colour, off.
// - LED k shows the rainbow rotated by (k mod 3) colour slots, so adjacent LEDs are 120 deg apart.
// - Sits between the board control regs (mode/period/static colour) and the per-LED PWM blocks.

---
 rtl/led_pattern_pkg.sv | 36 +++
 rtl/tick_divider.sv | 55 +++++
 rtl/led_pattern_gen.sv | 191 +++++++++++++++++++
 tb/tb_led_pattern_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// -----------------------------------------------------------------------------
// led_pattern_pkg
// Shared definitions for the LED pattern engine:
//   - mode encoding of the board control register
//   - pattern FSM state type (also exported on the debug port)
//   - helpers for per-LED colour rotation
// -----------------------------------------------------------------------------
package led_pattern_pkg;

   localparam logic [1:0] MODE_RAINBOW = 2'd0;
   localparam logic [1:0] MODE_BREATHE = 2'd1;
   localparam logic [1:0] MODE_STATIC  = 2'd2;
   localparam logic [1:0] MODE_OFF     = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUP    = 3'd1,
      S_GUP    = 3'd2,
      S_BUP    = 3'd3,
      S_WUP    = 3'd4,
      S_WDN    = 3'd5,
      S_STATIC = 3'd6,
      S_OFF    = 3'd7
   } state_e;

   // Colour-slot rotation for LED k: adjacent LEDs sit 120 degrees apart.
   function automatic logic [1:0] rot_slot(input int unsigned k);
      return 2'(k % 3);
   endfunction

   // Rotation applies only while a rainbow ramp is running.
   function automatic logic is_rainbow(input state_e s);
      return (s == S_RUP) || (s == S_GUP) || (s == S_BUP);
   endfunction

endpackage

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Free-running clock divider producing one tick every TICKS[period_sel] clocks.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   enable       1 = count; 0 = hold the counter, no tick
//   clear        restart the count (pattern restart); acts only while enabled
//   period_sel   selects TICKS0..TICKS3
//   tick         combinational one-clock strobe
// -----------------------------------------------------------------------------
module tick_divider #(
   parameter int TICKS0 = 25000,
   parameter int TICKS1 = 75000,
   parameter int TICKS2 = 500000,
   parameter int TICKS3 = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       clear,
   input  logic [1:0] period_sel,
   output logic       tick
);

   localparam int T01  = (TICKS0 > TICKS1) ? TICKS0 : TICKS1;
   localparam int T23  = (TICKS2 > TICKS3) ? TICKS2 : TICKS3;
   localparam int TMAX = (T01 > T23) ? T01 : T23;
   localparam int CW   = $clog2(TMAX + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] lim;

   always_comb begin
      lim = CW'(TICKS0 - 1);
      case (period_sel)
         2'd0:    lim = CW'(TICKS0 - 1);
         2'd1:    lim = CW'(TICKS1 - 1);
         2'd2:    lim = CW'(TICKS2 - 1);
         default: lim = CW'(TICKS3 - 1);
      endcase
   end

   // >= rather than == so that switching to a shorter period while the
   // count is already past the new limit ticks on the next enabled clock.
   assign tick = enable && !clear && (cnt_q >= lim);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= (clear || tick) ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
// Multi-LED RGB pattern engine producing PWM duty words for N_LEDS LEDs.
// Modes: rainbow crossfade, white breathe, static colour, off.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   enable       1 = run; 0 = freeze counters, state, base colour and outputs
//   mode         0 rainbow, 1 breathe, 2 static, 3 off
//   period_sel   clocks per ramp increment (TICKS0..TICKS3)
//   static_rgb   {r,g,b} shown in static mode
//   red/green/blue  LED k duty at [k*WIDTH +: WIDTH], registered
//   cycle_done   one-clock pulse at the end of a rainbow cycle / breathe period
//   dbg_state    current pattern FSM state
// -----------------------------------------------------------------------------
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int N_LEDS         = 2,
   parameter int WIDTH          = 15,
   parameter int INCREMENT      = 4,
   parameter int INCS_PER_STATE = 2000,
   parameter int TICKS0         = 25000,
   parameter int TICKS1         = 75000,
   parameter int TICKS2         = 500000,
   parameter int TICKS3         = 1000000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [1:0]               mode,
   input  logic [1:0]               period_sel,
   input  logic [3*WIDTH-1:0]       static_rgb,
   output logic [N_LEDS*WIDTH-1:0]  red,
   output logic [N_LEDS*WIDTH-1:0]  green,
   output logic [N_LEDS*WIDTH-1:0]  blue,
   output logic                     cycle_done,
   output state_e                   dbg_state
);

   localparam int               IW       = (INCS_PER_STATE > 1) ? $clog2(INCS_PER_STATE) : 1;
   localparam logic [IW-1:0]    INC_LAST = IW'(INCS_PER_STATE - 1);
   localparam logic [WIDTH-1:0] INC_V    = WIDTH'(INCREMENT);
   localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(INCREMENT * INCS_PER_STATE);

   state_e           state_q;
   logic [1:0]       mode_q;
   logic [IW-1:0]    incs_q;
   logic [WIDTH-1:0] r_q, g_q, b_q;
   logic             done_q;
   logic             tick;

   tick_divider #(
      .TICKS0 (TICKS0),
      .TICKS1 (TICKS1),
      .TICKS2 (TICKS2),
      .TICKS3 (TICKS3)
   ) u_div (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .clear      (state_q == S_IDLE),
      .period_sel (period_sel),
      .tick       (tick)
   );

   // Pattern FSM with the base colour triple. Ramps start from an exact
   // endpoint and take INCS_PER_STATE equal steps, so every channel lands
   // exactly on 0 or MAX at a state change and never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         mode_q  <= MODE_RAINBOW;
         incs_q  <= '0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         mode_q <= mode;
         done_q <= 1'b0;
         if (mode != mode_q) begin
            // Any mode change restarts the pattern, even while disabled.
            state_q <= S_IDLE;
         end else if (enable) begin
            case (state_q)
               S_IDLE: begin
                  incs_q <= '0;
                  case (mode_q)
                     MODE_RAINBOW: begin
                        {r_q, g_q, b_q} <= {{WIDTH{1'b0}}, {WIDTH{1'b0}}, MAX_V};
                        state_q <= S_RUP;
                     end
                     MODE_BREATHE: begin
                        {r_q, g_q, b_q} <= '0;
                        state_q <= S_WUP;
                     end
                     MODE_STATIC: begin
                        {r_q, g_q, b_q} <= static_rgb;
                        state_q <= S_STATIC;
                     end
                     default: begin
                        {r_q, g_q, b_q} <= '0;
                        state_q <= S_OFF;
                     end
                  endcase
               end
               S_RUP: if (tick) begin
                  r_q <= r_q + INC_V;
                  b_q <= b_q - INC_V;
                  g_q <= '0;
                  if (incs_q == INC_LAST) begin
                     incs_q  <= '0;
                     state_q <= S_GUP;
                  end else incs_q <= incs_q + 1'b1;
               end
               S_GUP: if (tick) begin
                  g_q <= g_q + INC_V;
                  r_q <= r_q - INC_V;
                  b_q <= '0;
                  if (incs_q == INC_LAST) begin
                     incs_q  <= '0;
                     state_q <= S_BUP;
                  end else incs_q <= incs_q + 1'b1;
               end
               S_BUP: if (tick) begin
                  b_q <= b_q + INC_V;
                  g_q <= g_q - INC_V;
                  r_q <= '0;
                  if (incs_q == INC_LAST) begin
                     incs_q  <= '0;
                     state_q <= S_RUP;
                     done_q  <= 1'b1;
                  end else incs_q <= incs_q + 1'b1;
               end
               S_WUP: if (tick) begin
                  r_q <= r_q + INC_V;
                  g_q <= g_q + INC_V;
                  b_q <= b_q + INC_V;
                  if (incs_q == INC_LAST) begin
                     incs_q  <= '0;
                     state_q <= S_WDN;
                  end else incs_q <= incs_q + 1'b1;
               end
               S_WDN: if (tick) begin
                  r_q <= r_q - INC_V;
                  g_q <= g_q - INC_V;
                  b_q <= b_q - INC_V;
                  if (incs_q == INC_LAST) begin
                     incs_q  <= '0;
                     state_q <= S_WUP;
                     done_q  <= 1'b1;
                  end else incs_q <= incs_q + 1'b1;
               end
               S_STATIC: {r_q, g_q, b_q} <= static_rgb;
               S_OFF:    {r_q, g_q, b_q} <= '0;
               default:  state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign cycle_done = done_q;
   assign dbg_state  = state_q;

   // Per-LED output registers with rainbow rotation by (k mod 3) slots.
   for (genvar k = 0; k < N_LEDS; k++) begin : g_led
      localparam logic [1:0] SLOT = rot_slot(k);
      logic [WIDTH-1:0] ro_q, go_q, bo_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            {ro_q, go_q, bo_q} <= '0;
         end else if (enable) begin
            if (is_rainbow(state_q)) begin
               case (SLOT)
                  2'd1:    {ro_q, go_q, bo_q} <= {b_q, r_q, g_q};
                  2'd2:    {ro_q, go_q, bo_q} <= {g_q, b_q, r_q};
                  default: {ro_q, go_q, bo_q} <= {r_q, g_q, b_q};
               endcase
            end else begin
               {ro_q, go_q, bo_q} <= {r_q, g_q, b_q};
            end
         end
      end

      assign red  [k*WIDTH +: WIDTH] = ro_q;
      assign green[k*WIDTH +: WIDTH] = go_q;
      assign blue [k*WIDTH +: WIDTH] = bo_q;
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;
   import led_pattern_pkg::*;

   localparam int N    = 3;
   localparam int W    = 15;
   localparam int INC  = 4;
   localparam int IPS  = 4;
   localparam int MAXV = INC * IPS;
   localparam int T0 = 3, T1 = 2, T2 = 5, T3 = 4;

   // ---------------- clock / reset / DUT ----------------
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             enable = 1'b0;
   logic [1:0]       mode = 2'd0;
   logic [1:0]       period_sel = 2'd0;
   logic [3*W-1:0]   static_rgb = '0;
   logic [N*W-1:0]   red, green, blue;
   logic             cycle_done;
   state_e           dbg_state;

   always #5 clk = ~clk;

   led_pattern_gen #(
      .N_LEDS(N), .WIDTH(W), .INCREMENT(INC), .INCS_PER_STATE(IPS),
      .TICKS0(T0), .TICKS1(T1), .TICKS2(T2), .TICKS3(T3)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode),
      .period_sel(period_sel), .static_rgb(static_rgb),
      .red(red), .green(green), .blue(blue),
      .cycle_done(cycle_done), .dbg_state(dbg_state)
   );

   int vectors = 0;
   int miscompares = 0;

   // ---------------- reference model ----------------
   // Pattern values are computed directly from the number of ticks since the
   // pattern started; only the tick timing is tracked cycle by cycle.
   int m_mq, m_pat, m_cnt, m_t;
   bit m_idle, m_rain, m_done;
   int mb[3];
   int mo[N][3];

   function automatic int ticks_of(input logic [1:0] s);
      case (s)
         2'd0:    return T0;
         2'd1:    return T1;
         2'd2:    return T2;
         default: return T3;
      endcase
   endfunction

   // ch: 0 red, 1 green, 2 blue
   function automatic int pat_val(input int md, input int t, input int ch);
      int p, seg, x;
      if (md == 0) begin
         p   = t % (3 * IPS);
         seg = p / IPS;
         x   = (p % IPS) * INC;
         if (ch == seg) return x;
         if (ch == (seg + 2) % 3) return MAXV - x;
         return 0;
      end
      p = t % (2 * IPS);
      return (p < IPS) ? p * INC : MAXV - (p - IPS) * INC;
   endfunction

   task automatic model_reset();
      m_mq = 0; m_pat = 3; m_cnt = 0; m_t = 0;
      m_idle = 1; m_rain = 0; m_done = 0;
      for (int c = 0; c < 3; c++) mb[c] = 0;
      for (int k = 0; k < N; k++) for (int c = 0; c < 3; c++) mo[k][c] = 0;
   endtask

   task automatic load_base();
      for (int c = 0; c < 3; c++) begin
         if (m_pat < 2)       mb[c] = pat_val(m_pat, m_t, c);
         else if (m_pat == 2) mb[c] = int'(static_rgb[(2-c)*W +: W]);
         else                 mb[c] = 0;
      end
   endtask

   // Advance the model across one rising edge using the inputs seen there.
   task automatic model_step();
      bit tk;
      if (enable)
         for (int k = 0; k < N; k++)
            for (int c = 0; c < 3; c++)
               mo[k][c] = m_rain ? mb[(c + 3 - (k % 3)) % 3] : mb[c];
      tk = enable && !m_idle && (m_cnt >= ticks_of(period_sel) - 1);
      if (enable) m_cnt = (m_idle || tk) ? 0 : m_cnt + 1;
      m_done = 0;
      if (int'(mode) != m_mq) begin
         m_mq   = int'(mode);
         m_idle = 1;
      end else if (enable) begin
         if (m_idle) begin
            m_idle = 0; m_pat = m_mq; m_t = 0;
            load_base();
         end else if (m_pat < 2 && tk) begin
            m_t++;
            load_base();
            m_done = (m_t % ((m_pat == 0) ? 3 * IPS : 2 * IPS)) == 0;
         end else if (m_pat == 2) begin
            load_base();
         end
      end
      m_rain = !m_idle && (m_pat == 0);
   endtask

   // ---------------- scoreboard checks ----------------
   task automatic check_model(input string tag);
      logic [N*W-1:0] er, eg, eb;
      for (int k = 0; k < N; k++) begin
         er[k*W +: W] = W'(mo[k][0]);
         eg[k*W +: W] = W'(mo[k][1]);
         eb[k*W +: W] = W'(mo[k][2]);
      end
      vectors++;
      assert (red === er && green === eg && blue === eb && cycle_done === m_done)
      else begin
         miscompares++;
         $error("FAIL %s: got r=%h g=%h b=%h done=%b, expected r=%h g=%h b=%h done=%b",
                tag, red, green, blue, cycle_done, er, eg, eb, m_done);
      end
   endtask

   task automatic check_led(input string tag, input int k, input int r, input int g, input int b);
      vectors++;
      assert (red[k*W +: W] === W'(r) && green[k*W +: W] === W'(g) && blue[k*W +: W] === W'(b))
      else begin
         miscompares++;
         $error("FAIL %s: LED%0d got (%0d,%0d,%0d), expected (%0d,%0d,%0d)", tag, k,
                red[k*W +: W], green[k*W +: W], blue[k*W +: W], r, g, b);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1;
      model_step();
      check_model(tag);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int pulses;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) check_led("reset_out", k, 0, 0, 0);
      vectors++;
      assert (cycle_done === 1'b0 && dbg_state === S_IDLE)
      else begin
         miscompares++;
         $error("FAIL reset_ctl: got done=%b state=%0d, expected done=0 state=0", cycle_done, dbg_state);
      end

      // Rainbow start-up
      rst = 1'b0; enable = 1'b1; mode = 2'd0; period_sel = 2'd0;
      step("rb_idle");
      step("rb_first");
      check_led("rb_start", 0, 0, 0, MAXV);
      repeat (3) step("rb_ramp");
      check_led("rb_tick1_led0", 0, 4, 0, 12);
      check_led("rb_tick1_led1", 1, 12, 4, 0);
      check_led("rb_tick1_led2", 2, 0, 12, 4);

      // Remainder of one full rainbow cycle: exactly one cycle_done pulse
      pulses = 0;
      for (int i = 0; i < 36; i++) begin
         step("rb_cycle");
         if (cycle_done === 1'b1) pulses++;
      end
      vectors++;
      assert (pulses === 1)
      else begin
         miscompares++;
         $error("FAIL rb_done_pulses: got %0d, expected 1", pulses);
      end

      // Breathe: one full period yields one pulse
      mode = 2'd1;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         step("br_ramp");
         if (cycle_done === 1'b1) pulses++;
      end
      vectors++;
      assert (pulses === 1)
      else begin
         miscompares++;
         $error("FAIL br_done_pulses: got %0d, expected 1", pulses);
      end

      // Static colour, then live follow
      mode = 2'd2;
      static_rgb = {15'd100, 15'd200, 15'd300};
      repeat (3) step("st_load");
      for (int k = 0; k < N; k++) check_led("st_value", k, 100, 200, 300);
      static_rgb = {15'($urandom), 15'($urandom), 15'($urandom)};
      repeat (2) step("st_follow");

      // Freeze mid-ramp and resume
      mode = 2'd0;
      repeat (10) step("en_pre");
      enable = 1'b0;
      repeat (20) step("en_frozen");
      enable = 1'b1;
      repeat (20) step("en_resume");

      // Randomized mode/period/enable/colour traffic
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) period_sel = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0)
            static_rgb = {15'($urandom), 15'($urandom), 15'($urandom)};
         enable = ($urandom_range(0, 9) != 0);
         step("random");
      end

      // Async reset mid-ramp with no clock edge
      mode = 2'd0; enable = 1'b1; period_sel = 2'd0;
      repeat (8) step("ar_pre");
      rst = 1'b1;
      #2;
      for (int k = 0; k < N; k++) check_led("async_rst", k, 0, 0, 0);
      model_reset();
      @(posedge clk);
      #3 rst = 1'b0;

      // Rainbow then off
      repeat (6) step("off_pre");
      mode = 2'd3;
      repeat (3) step("off");
      for (int k = 0; k < N; k++) check_led("off_value", k, 0, 0, 0);
      repeat (10) step("off_hold");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
